// File: rtl/bitflip_event_logger_pkg.sv
`default_nettype none
// ============================================================================
// Package  : bitflip_pkg
// Purpose  : Event record type and saturating-add helper for the logger.
// Revision : 1.0 - initial release
// ============================================================================
package bitflip_pkg;

    // Record field widths match the default build (8 sensors, 16-bit stamp).
    localparam int unsigned c_rec_id_w = 3;
    localparam int unsigned c_rec_ts_w = 16;

    typedef struct packed {
        logic [c_rec_id_w-1:0] sensor_id;
        logic [c_rec_ts_w-1:0] timestamp;
        logic                  lost;
    } bitflip_rec_t;

    // Adds inc to val and clamps at the all-ones value of a width-bit counter.
    function automatic logic [31:0] sat_add(input logic [31:0] val,
                                            input logic [31:0] inc,
                                            input int unsigned width);
        logic [32:0] sum;
        logic [32:0] lim;
        sum = {1'b0, val} + {1'b0, inc};
        lim = (33'd1 << width) - 33'd1;
        return (sum > lim) ? lim[31:0] : sum[31:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/bitflip_event_logger_if.sv
`default_nettype none
// ============================================================================
// Module   : bitflip_event_logger_if
// Purpose  : Valid/ready record channel from the logger to its reporter.
// Revision : 1.0 - initial release
// ============================================================================
interface bitflip_event_logger_if
    import bitflip_pkg::*;
#(
    parameter int ID_W = 3,
    parameter int TS_W = 16
);
    logic            rec_valid;
    logic            rec_ready;
    logic [ID_W-1:0] rec_sensor_id;
    logic [TS_W-1:0] rec_timestamp;
    logic            rec_lost;

    modport master (
        output rec_valid, rec_sensor_id, rec_timestamp, rec_lost,
        input  rec_ready
    );

    modport slave (
        input  rec_valid, rec_sensor_id, rec_timestamp, rec_lost,
        output rec_ready
    );
endinterface
`default_nettype wire

// File: rtl/bitflip_event_logger_fifo.sv
`default_nettype none
// ============================================================================
// Module   : bitflip_event_fifo
// Purpose  : DEPTH-entry record FIFO; timestamp storage exists only when
//            BITFLIP_LOGGER_TIMESTAMP_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module bitflip_event_fifo
    import bitflip_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_push,
    input  wire logic              i_pop,
    input  wire bitflip_rec_t      i_rec,
    output bitflip_rec_t           o_head,
    output logic [$clog2(DEPTH):0] o_level
);
    localparam int c_ptr_w = $clog2(DEPTH);
    localparam logic [c_ptr_w-1:0] c_ptr_one = 1;
    localparam logic [c_ptr_w:0]   c_lvl_one = 1;

    logic [c_ptr_w-1:0]    r_wr_ptr;
    logic [c_ptr_w-1:0]    r_rd_ptr;
    logic [c_ptr_w:0]      r_level;
    logic [c_rec_id_w-1:0] r_id_mem   [DEPTH];
    logic                  r_lost_mem [DEPTH];

    // Callers never push into a full FIFO without a pop, nor pop when empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_id_mem[i]   <= '0;
                r_lost_mem[i] <= 1'b0;
            end
        end else begin
            if (i_push) begin
                r_id_mem[r_wr_ptr]   <= i_rec.sensor_id;
                r_lost_mem[r_wr_ptr] <= i_rec.lost;
                r_wr_ptr             <= r_wr_ptr + c_ptr_one;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            if (i_push && !i_pop) begin
                r_level <= r_level + c_lvl_one;
            end else if (!i_push && i_pop) begin
                r_level <= r_level - c_lvl_one;
            end
        end
    end

`ifdef BITFLIP_LOGGER_TIMESTAMP_EN
    logic [c_rec_ts_w-1:0] r_ts_mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_ts_mem[i] <= '0;
            end
        end else if (i_push) begin
            r_ts_mem[r_wr_ptr] <= i_rec.timestamp;
        end
    end
`else
    logic [c_rec_ts_w-1:0] w_unused_ts;
    assign w_unused_ts = i_rec.timestamp;
`endif

    always_comb begin
        o_head           = '0;
        o_head.sensor_id = r_id_mem[r_rd_ptr];
        o_head.lost      = r_lost_mem[r_rd_ptr];
`ifdef BITFLIP_LOGGER_TIMESTAMP_EN
        o_head.timestamp = r_ts_mem[r_rd_ptr];
`endif
    end

    assign o_level = r_level;

endmodule
`default_nettype wire

// File: rtl/bitflip_event_logger.sv
`default_nettype none
// ============================================================================
// Module   : bitflip_event_logger
// Purpose  : Turns sensor error rising edges into queued event records with
//            saturating totals. Optional BITFLIP_LOGGER_TIMESTAMP_EN adds a
//            cycle timestamp to each record.
// Revision : 1.0 - initial release
// ============================================================================
module bitflip_event_logger
    import bitflip_pkg::*;
#(
    parameter int SENSORS = 8,
    parameter int DEPTH   = 4,
    parameter int TS_W    = 16,
    parameter int CNT_W   = 16
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic [SENSORS-1:0]  sensor_error,
    input  wire logic                clear,
    bitflip_event_logger_if.master   rec_if,
    output logic [CNT_W-1:0]         total_count,
    output logic [CNT_W-1:0]         dropped_count,
    output logic [$clog2(DEPTH):0]   fifo_level
);
    localparam int c_id_w  = $clog2(SENSORS);
    localparam int c_lvl_w = $clog2(DEPTH) + 1;
    localparam logic [c_lvl_w-1:0] c_full_level = c_lvl_w'(DEPTH);

    logic [SENSORS-1:0] r_prev;
    logic [SENSORS-1:0] r_pending;
    logic               r_lost;
    logic [CNT_W-1:0]   r_total;
    logic [CNT_W-1:0]   r_dropped;

    logic [SENSORS-1:0]    w_rise;
    logic [SENSORS-1:0]    w_drop;
    logic [SENSORS-1:0]    w_accept;
    logic [SENSORS-1:0]    w_grant_mask;
    logic [c_id_w-1:0]     w_grant_idx;
    logic                  w_any;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic [c_lvl_w-1:0]    w_level;
    logic [c_rec_ts_w-1:0] w_ts;
    bitflip_rec_t          w_push_rec;
    bitflip_rec_t          w_head;

    assign w_rise = sensor_error & ~r_prev;

    // Lowest pending index wins; scanning downward leaves the lowest last.
    always_comb begin
        w_grant_idx = '0;
        w_any       = 1'b0;
        for (int i = SENSORS - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_grant_idx = c_id_w'(i);
                w_any       = 1'b1;
            end
        end
    end

    assign w_full       = (w_level == c_full_level);
    assign w_pop        = rec_if.rec_valid & rec_if.rec_ready;
    assign w_push       = w_any & (~w_full | w_pop);
    assign w_grant_mask = w_push ? (SENSORS'(1) << w_grant_idx) : '0;
    // A rise on the sensor being granted this cycle re-arms it, not a drop.
    assign w_drop       = w_rise & r_pending & ~w_grant_mask;
    assign w_accept     = w_rise & ~w_drop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev    <= '0;
            r_pending <= '0;
            r_lost    <= 1'b0;
            r_total   <= '0;
            r_dropped <= '0;
        end else begin
            r_prev    <= sensor_error;
            r_pending <= (r_pending & ~w_grant_mask) | w_rise;
            r_lost    <= (r_lost & ~w_push) | (|w_drop);
            if (clear) begin
                r_total   <= '0;
                r_dropped <= '0;
            end else begin
                r_total   <= CNT_W'(sat_add(32'(r_total),
                                            32'($countones(w_accept)), CNT_W));
                r_dropped <= CNT_W'(sat_add(32'(r_dropped),
                                            32'($countones(w_drop)), CNT_W));
            end
        end
    end

`ifdef BITFLIP_LOGGER_TIMESTAMP_EN
    logic [TS_W-1:0] r_ts;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ts <= '0;
        end else if (clear) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + TS_W'(1);
        end
    end

    assign w_ts = c_rec_ts_w'(r_ts);
`else
    assign w_ts = '0;
`endif

    always_comb begin
        w_push_rec           = '0;
        w_push_rec.sensor_id = c_rec_id_w'(w_grant_idx);
        w_push_rec.timestamp = w_ts;
        w_push_rec.lost      = r_lost;
    end

    bitflip_event_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_rec   (w_push_rec),
        .o_head  (w_head),
        .o_level (w_level)
    );

    assign rec_if.rec_valid     = (w_level != '0);
    assign rec_if.rec_sensor_id = c_id_w'(w_head.sensor_id);
    assign rec_if.rec_timestamp = TS_W'(w_head.timestamp);
    assign rec_if.rec_lost      = w_head.lost;
    assign total_count          = r_total;
    assign dropped_count        = r_dropped;
    assign fifo_level           = w_level;

endmodule
`default_nettype wire
